// File: rtl/seq_core_data_memory_pkg.sv
// Shared types and constants for the sequential core data-memory responder.
// Holds the FSM encoding and the wait-state counter width.
package seq_core_data_memory_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_t;

    function automatic logic [CNT_W-1:0] wait_load(input int ws);
        return CNT_W'(ws);
    endfunction

endpackage

// File: rtl/seq_core_write_buffer.sv
// One-entry posted-write buffer. Drains into the word array whenever the
// array port is free and offers its contents for forwarding to reads.
module seq_core_write_buffer
    import seq_core_data_memory_pkg::*;
#(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [A_SIZE-1:0] load_addr,
    input  logic [D_SIZE-1:0] load_data,
    input  logic              drain_en,
    input  logic [A_SIZE-1:0] match_addr,
    output logic [A_SIZE-1:0] buf_addr,
    output logic [D_SIZE-1:0] buf_data,
    output logic              drain,
    output logic              hit
);

    logic buf_valid;

    assign drain = buf_valid & drain_en;
    assign hit   = buf_valid & (buf_addr == match_addr);

    // A load on a draining edge is legal: the old entry leaves via drain,
    // the new one takes its place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            if (load) begin
                buf_valid <= 1'b1;
                buf_addr  <= load_addr;
                buf_data  <= load_data;
            end else if (drain) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_core_data_memory.sv
// Data-memory responder for the execute stage: single-port word array,
// posted writes through a one-entry buffer, wait-stated reads with stall.
//
// state     | meaning
// ST_IDLE   | accept writes; a read raises stall and starts the access
// ST_ACCESS | wait-state countdown; capture load data when cnt reaches 0
// ST_RESP   | rd_valid pulse, stall released, core advances
module seq_core_data_memory
    import seq_core_data_memory_pkg::*;
#(
    parameter int D_SIZE      = 32,
    parameter int A_SIZE      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [A_SIZE-1:0] address,
    input  logic [D_SIZE-1:0] data_in,
    output logic [D_SIZE-1:0] data_out,
    output logic              rd_valid,
    output logic              stall,
    output logic              error
);

    localparam logic [CNT_W-1:0] WAIT_INIT = wait_load(WAIT_STATES);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [A_SIZE-1:0] addr_q;
    logic [D_SIZE-1:0] mem [2**A_SIZE];

    logic              capture;
    logic              accept;
    logic              violation;
    logic              stall_c;
    logic [A_SIZE-1:0] buf_addr;
    logic [D_SIZE-1:0] buf_data;
    logic              drain;
    logic              hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_c   = 1'b0;
        rd_valid  = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        violation = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read) begin
                    stall_c   = 1'b1;
                    cnt_d     = WAIT_INIT;
                    state_d   = ST_ACCESS;
                    violation = write;
                end else if (write) begin
                    accept = 1'b1;
                end
            end
            ST_ACCESS: begin
                stall_c   = 1'b1;
                violation = write;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rd_valid = 1'b1;
                state_d  = ST_IDLE;
                accept   = write & ~read;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset must drop stall immediately even if the core still holds read.
    assign stall = stall_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            data_out <= '0;
            error    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && read) begin
                addr_q <= address;
            end
            if (capture) begin
                data_out <= hit ? buf_data : mem[addr_q];
            end
            if (violation) begin
                error <= 1'b1;
            end
        end
    end

    // Capture owns the single array port; the buffer only drains otherwise.
    always_ff @(posedge clk) begin
        if (drain) begin
            mem[buf_addr] <= buf_data;
        end
    end

    seq_core_write_buffer #(
        .D_SIZE (D_SIZE),
        .A_SIZE (A_SIZE)
    ) u_write_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_addr  (address),
        .load_data  (data_in),
        .drain_en   (~capture),
        .match_addr (addr_q),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .drain      (drain),
        .hit        (hit)
    );

endmodule

// File: tb/tb_seq_core_data_memory.sv
// Scoreboard bench for seq_core_data_memory: two instances (2 and 0 wait
// states), loads push expected data, a negedge monitor pops and compares.
module tb_seq_core_data_memory;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        read_s     [2];
    logic        write_s    [2];
    logic [9:0]  addr_s     [2];
    logic [31:0] din_s      [2];
    logic [31:0] dout_s     [2];
    logic        rd_valid_s [2];
    logic        stall_s    [2];
    logic        error_s    [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    seq_core_data_memory #(.D_SIZE(32), .A_SIZE(10), .WAIT_STATES(2)) dut_w2 (
        .clk(clk), .rst(rst), .read(read_s[0]), .write(write_s[0]),
        .address(addr_s[0]), .data_in(din_s[0]), .data_out(dout_s[0]),
        .rd_valid(rd_valid_s[0]), .stall(stall_s[0]), .error(error_s[0])
    );

    seq_core_data_memory #(.D_SIZE(32), .A_SIZE(10), .WAIT_STATES(0)) dut_w0 (
        .clk(clk), .rst(rst), .read(read_s[1]), .write(write_s[1]),
        .address(addr_s[1]), .data_in(din_s[1]), .data_out(dout_s[1]),
        .rd_valid(rd_valid_s[1]), .stall(stall_s[1]), .error(error_s[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding load.
    always @(negedge clk) begin
        if (rd_valid_s[0] === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid_w2: data 0x%08h with no load pending", dout_s[0]);
            end else begin
                check("load_data_w2", dout_s[0], q0.pop_front());
            end
        end
        if (rd_valid_s[1] === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid_w0: data 0x%08h with no load pending", dout_s[1]);
            end else begin
                check("load_data_w0", dout_s[1], q1.pop_front());
            end
        end
    end

    task automatic wr(input int i, input logic [9:0] a, input logic [31:0] d);
        read_s[i]  = 1'b0;
        write_s[i] = 1'b1;
        addr_s[i]  = a;
        din_s[i]   = d;
        @(negedge clk);
        check("write_no_stall", {31'd0, stall_s[i]}, 32'd0);
        @(posedge clk);
        #1;
        write_s[i] = 1'b0;
    endtask

    // wr_mode: 0 plain load, 1 write together with the request, 2 write during ACCESS
    task automatic rd(input int i, input logic [9:0] a, input logic [31:0] exp, input int wr_mode);
        int cyc    = 0;
        int stalls = 0;
        int ws     = (i == 0) ? 2 : 0;
        bit got    = 1'b0;
        if (i == 0) q0.push_back(exp);
        else        q1.push_back(exp);
        read_s[i]  = 1'b1;
        addr_s[i]  = a;
        din_s[i]   = 32'h1234_5678;
        write_s[i] = (wr_mode == 1);
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (rd_valid_s[i] === 1'b1) begin
                got = 1'b1;
            end else begin
                if (stall_s[i] === 1'b1) stalls++;
                cyc++;
                @(posedge clk);
                #1;
                write_s[i] = (wr_mode == 2 && cyc == 1);
            end
        end
        if (!got) $display("FAIL rd_valid_timeout: no rd_valid within %0d cycles, expected %0d", cyc, ws + 2);
        check("read_latency", 32'(cyc), 32'(ws + 2));
        check("stall_cycles", 32'(stalls), 32'(ws + 2));
        @(posedge clk);
        #1;
        read_s[i]  = 1'b0;
        write_s[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            read_s[i]  = 1'b0;
            write_s[i] = 1'b0;
            addr_s[i]  = '0;
            din_s[i]   = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_data_out", dout_s[i], 32'd0);
            check("reset_rd_valid", {31'd0, rd_valid_s[i]}, 32'd0);
            check("reset_stall",    {31'd0, stall_s[i]}, 32'd0);
            check("reset_error",    {31'd0, error_s[i]}, 32'd0);
        end
        @(posedge clk);
        #1;

        // store then immediate load
        wr(0, 10'h005, 32'hDEAD_BEEF);
        rd(0, 10'h005, 32'hDEAD_BEEF, 0);

        // back-to-back stores, then read each
        wr(0, 10'h010, 32'h1111_1111);
        wr(0, 10'h011, 32'h2222_2222);
        rd(0, 10'h010, 32'h1111_1111, 0);
        rd(0, 10'h011, 32'h2222_2222, 0);
        rd(0, 10'h005, 32'hDEAD_BEEF, 0);

        // zero-wait-state instance, top address
        wr(1, 10'h3FF, 32'h0000_ABCD);
        @(posedge clk);
        #1;
        rd(1, 10'h3FF, 32'h0000_ABCD, 0);
        repeat (2) @(negedge clk);
        check("data_out_hold_w0", dout_s[1], 32'h0000_ABCD);
        check("no_error_w0", {31'd0, error_s[1]}, 32'd0);
        @(posedge clk);
        #1;

        // simultaneous read and write: read served, write dropped, error sticky
        wr(0, 10'h020, 32'hAAAA_5555);
        rd(0, 10'h020, 32'hAAAA_5555, 0);
        check("error_before_violation", {31'd0, error_s[0]}, 32'd0);
        rd(0, 10'h020, 32'hAAAA_5555, 1);
        check("error_after_rd_wr", {31'd0, error_s[0]}, 32'd1);
        rd(0, 10'h020, 32'hAAAA_5555, 0);
        wr(0, 10'h021, 32'h0BAD_F00D);
        check("error_sticky", {31'd0, error_s[0]}, 32'd1);

        // reset in the middle of a read
        read_s[0] = 1'b1;
        addr_s[0] = 10'h020;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("stall_drops_on_rst", {31'd0, stall_s[0]}, 32'd0);
        check("error_cleared_by_rst", {31'd0, error_s[0]}, 32'd0);
        check("data_out_cleared_by_rst", dout_s[0], 32'd0);
        read_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rd(0, 10'h020, 32'hAAAA_5555, 0);
        rd(0, 10'h021, 32'h0BAD_F00D, 0);
        check("no_error_after_reset", {31'd0, error_s[0]}, 32'd0);

        // write arriving during ACCESS is ignored but flagged
        rd(0, 10'h020, 32'hAAAA_5555, 2);
        check("error_write_in_access", {31'd0, error_s[0]}, 32'd1);
        rd(0, 10'h020, 32'hAAAA_5555, 0);

        repeat (3) @(negedge clk);
        check("pending_loads_w2", 32'(q0.size()), 32'd0);
        check("pending_loads_w0", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
